// File: rtl/sisc_pkg.sv
// Shared constants and enums for the SISC memory arbiter slice.
package sisc_pkg;
    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_LS = 2'd1,
        REQ_LD = 2'd2
    } req_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;
endpackage

// File: rtl/sisc_mem_arbiter_if.sv
// Requester, grant/return and SRAM-side signals of the unified memory port.
interface sisc_mem_arbiter_if;
    import sisc_pkg::*;

    logic                if_req, ls_req, ld_req;
    logic [ADDRSIZE-1:0] if_addr, ls_addr, ld_addr;
    logic                ls_we, ld_we;
    logic [WIDTH-1:0]    ls_wdata, ld_wdata;
    logic                ld_lock;
    logic                if_gnt, ls_gnt, ld_gnt;
    logic                if_rvalid, ls_rvalid, ld_rvalid;
    logic [WIDTH-1:0]    rdata;
    logic                locked;
    logic                mem_en, mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    modport slave (
        input  if_req, ls_req, ld_req, if_addr, ls_addr, ld_addr,
               ls_we, ld_we, ls_wdata, ld_wdata, ld_lock, mem_rdata,
        output if_gnt, ls_gnt, ld_gnt, if_rvalid, ls_rvalid, ld_rvalid,
               rdata, locked, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, ls_req, ld_req, if_addr, ls_addr, ld_addr,
               ls_we, ld_we, ls_wdata, ld_wdata, ld_lock, mem_rdata,
        input  if_gnt, ls_gnt, ld_gnt, if_rvalid, ls_rvalid, ld_rvalid,
               rdata, locked, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sisc_rr_arb2.sv
// Two-way round-robin picker: ptr names the favoured input, ptr_next is the
// pointer to load after this cycle's grant.
module sisc_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_next
);
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        // a side wins when it is favoured or when the other side is idle
        assign gnt[gi] = req[gi] && ((ptr == 1'(gi)) || !req[1-gi]);
    end

    assign ptr_next = gnt[0] ? 1'b1 : (gnt[1] ? 1'b0 : ptr);
endmodule

// File: rtl/sisc_mem_arbiter.sv
// Shares the single 4096x32 SRAM port between fetch, load/store and loader,
// with a loader lock for exclusive bulk access and one-cycle read return.
module sisc_mem_arbiter
    import sisc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    sisc_mem_arbiter_if.slave bus
);
    state_e              state_reg, state_next;
    logic                rr_ptr_reg, rr_ptr_next;
    logic                tag_valid_reg, tag_valid_next;
    req_e                tag_reg, tag_next;
    logic [1:0]          arb_req, arb_gnt;
    logic [2:0]          gnt_vec, rvalid_vec;
    logic                mem_en_c, mem_we_c;
    logic [ADDRSIZE-1:0] mem_addr_c;
    logic [WIDTH-1:0]    mem_wdata_c;

    // IF/LS only compete while running, out of reset, and with LD idle;
    // a zero request vector also keeps the pointer frozen while locked.
    assign arb_req = (reset && state_reg == ST_RUN && !bus.ld_req)
                   ? {bus.ls_req, bus.if_req} : 2'b00;

    sisc_rr_arb2 u_rr_arb2 (
        .req      (arb_req),
        .ptr      (rr_ptr_reg),
        .gnt      (arb_gnt),
        .ptr_next (rr_ptr_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_RUN;
            rr_ptr_reg    <= 1'b0;
            tag_valid_reg <= 1'b0;
            tag_reg       <= REQ_IF;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            tag_valid_reg <= tag_valid_next;
            tag_reg       <= tag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (gnt_vec[REQ_LD] && bus.ld_lock) state_next = ST_LOCKED;
            ST_LOCKED: if (!bus.ld_lock) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    always_comb begin
        gnt_vec         = 3'b000;
        gnt_vec[REQ_LD] = reset && bus.ld_req;
        gnt_vec[REQ_IF] = arb_gnt[0];
        gnt_vec[REQ_LS] = arb_gnt[1];
        mem_en_c        = |gnt_vec;
        mem_we_c        = 1'b0;
        mem_addr_c      = bus.if_addr;
        mem_wdata_c     = '0;
        tag_next        = REQ_IF;
        if (gnt_vec[REQ_LD]) begin
            mem_we_c    = bus.ld_we;
            mem_addr_c  = bus.ld_addr;
            mem_wdata_c = bus.ld_wdata;
            tag_next    = REQ_LD;
        end else if (gnt_vec[REQ_LS]) begin
            mem_we_c    = bus.ls_we;
            mem_addr_c  = bus.ls_addr;
            mem_wdata_c = bus.ls_wdata;
            tag_next    = REQ_LS;
        end
        tag_valid_next = mem_en_c && !mem_we_c;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rvalid
        assign rvalid_vec[gi] = tag_valid_reg && (tag_reg == req_e'(2'(gi)));
    end

    assign bus.if_gnt    = gnt_vec[REQ_IF];
    assign bus.ls_gnt    = gnt_vec[REQ_LS];
    assign bus.ld_gnt    = gnt_vec[REQ_LD];
    assign bus.if_rvalid = rvalid_vec[REQ_IF];
    assign bus.ls_rvalid = rvalid_vec[REQ_LS];
    assign bus.ld_rvalid = rvalid_vec[REQ_LD];
    assign bus.rdata     = bus.mem_rdata;
    assign bus.locked    = (state_reg == ST_LOCKED);
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// Randomized and directed bench for sisc_mem_arbiter against a cycle-level
// behavioural model of the arbitration rules and a reference memory image.
module tb_sisc_mem_arbiter;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    sisc_mem_arbiter_if bus ();

    sisc_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro stand-in: registered read, one-cycle latency
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:4095];
    bit          m_locked;
    int          m_fav;      // 0 = IF favoured, 1 = LS favoured
    int          m_rd_who;   // requester owed read data next cycle, -1 none
    logic [31:0] m_rd_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; checks the
    // cycle, advances the model across the next posedge, returns at negedge.
    task automatic step(input bit late_rst, output int who);
        bit          we;
        logic [11:0] a;
        logic [31:0] wd;
        who = -1;
        we  = 1'b0;
        a   = '0;
        wd  = '0;
        if (reset) begin
            if (bus.ld_req) who = 2;
            else if (!m_locked) begin
                if (bus.if_req && bus.ls_req) who = m_fav;
                else if (bus.if_req)          who = 0;
                else if (bus.ls_req)          who = 1;
            end
        end
        case (who)
            0: a = bus.if_addr;
            1: begin we = bus.ls_we; a = bus.ls_addr; wd = bus.ls_wdata; end
            2: begin we = bus.ld_we; a = bus.ld_addr; wd = bus.ld_wdata; end
            default: ;
        endcase
        #1;
        check_val("gnt", {29'd0, bus.ld_gnt, bus.ls_gnt, bus.if_gnt}, (who < 0) ? 0 : (1 << who));
        check_val("mem_en", {31'd0, bus.mem_en}, {31'd0, who >= 0});
        if (who >= 0) begin
            check_val("mem_we", {31'd0, bus.mem_we}, {31'd0, we});
            check_val("mem_addr", {20'd0, bus.mem_addr}, {20'd0, a});
            if (we) check_val("mem_wdata", bus.mem_wdata, wd);
        end
        check_val("rvalid", {29'd0, bus.ld_rvalid, bus.ls_rvalid, bus.if_rvalid},
                  (m_rd_who < 0) ? 0 : (1 << m_rd_who));
        if (m_rd_who >= 0) check_val("rdata", bus.rdata, m_rd_data);
        check_val("locked", {31'd0, bus.locked}, {31'd0, m_locked});
        if (late_rst) begin
            reset = 1'b0;
            #1;
        end
        if (!reset) begin
            m_locked = 1'b0;
            m_fav    = 0;
            m_rd_who = -1;
            who      = -1;
        end else begin
            m_rd_who = -1;
            if (who >= 0) begin
                if (we) ref_mem[a] = wd;
                else begin
                    m_rd_who  = who;
                    m_rd_data = ref_mem[a];
                end
            end
            if (who == 0)      m_fav = 1;
            else if (who == 1) m_fav = 0;
            if (m_locked)      m_locked = bus.ld_lock;
            else if (who == 2 && bus.ld_lock) m_locked = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        int w;
        for (int i = 0; i < n; i++) step(1'b0, w);
    endtask

    initial begin
        int w;
        int last_who;
        for (int i = 0; i < 4096; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        m_locked = 1'b0; m_fav = 0; m_rd_who = -1; m_rd_data = '0;
        reset = 1'b0;
        bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.ld_req = 1'b1; bus.ld_lock = 1'b0;
        bus.if_addr = 12'h010; bus.ls_addr = 12'h020; bus.ld_addr = 12'h100;
        bus.ls_we = 1'b0; bus.ld_we = 1'b0; bus.ls_wdata = '0; bus.ld_wdata = '0;

        // reset held with every requester active
        @(posedge clk);
        @(negedge clk);
        step(1'b0, w);
        reset = 1'b1;

        // IF/LS round-robin with LD idle
        bus.ld_req = 1'b0;
        run(6);

        // locked bulk writes from the loader
        bus.ld_req = 1'b1; bus.ld_lock = 1'b1; bus.ld_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_addr  = 12'(12'h100 + i);
            bus.ld_wdata = 32'hDEADBEEF + i;
            step(1'b0, w);
        end
        bus.ld_req = 1'b0; bus.ld_lock = 1'b0;
        run(4);

        // LS write then read-back of the same word
        bus.if_req = 1'b0; bus.ls_addr = 12'h3FF; bus.ls_we = 1'b1; bus.ls_wdata = 32'h0000CAFE;
        step(1'b0, w);
        bus.ls_we = 1'b0;
        step(1'b0, w);
        bus.ls_req = 1'b0;
        step(1'b0, w);

        // LS request withdrawn while LD owns the port
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 12'h123;
        bus.ls_req = 1'b1; bus.ls_addr = 12'h2AB;
        step(1'b0, w);
        bus.ls_req = 1'b0;
        step(1'b0, w);
        bus.ld_req = 1'b0;
        step(1'b0, w);

        // reset arriving at the edge that would capture an IF read
        bus.if_req = 1'b1; bus.if_addr = 12'h055;
        step(1'b1, w);
        step(1'b0, w);
        reset = 1'b1;
        bus.if_req = 1'b0;
        step(1'b0, w);

        // random traffic obeying the hold-until-granted rule
        last_who = -1;
        for (int i = 0; i < 600; i++) begin
            if (bus.if_req && last_who != 0) begin
                if ($urandom_range(0, 15) == 0) bus.if_req = 1'b0;
            end else begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = 12'($urandom_range(0, 31));
            end
            if (bus.ls_req && last_who != 1) begin
                if ($urandom_range(0, 15) == 0) bus.ls_req = 1'b0;
            end else begin
                bus.ls_req   = ($urandom_range(0, 2) != 0);
                bus.ls_addr  = 12'($urandom_range(0, 31));
                bus.ls_we    = ($urandom_range(0, 2) == 0);
                bus.ls_wdata = $urandom;
            end
            if (bus.ld_req && last_who != 2) begin
                if ($urandom_range(0, 15) == 0) bus.ld_req = 1'b0;
            end else begin
                bus.ld_req   = ($urandom_range(0, 4) == 0);
                bus.ld_addr  = 12'($urandom);
                bus.ld_we    = ($urandom_range(0, 1) == 0);
                bus.ld_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) bus.ld_lock = ~bus.ld_lock;
            reset = ($urandom_range(0, 79) != 0);
            step(1'b0, last_who);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sisc_mem_arbiter.md
# sisc_mem_arbiter

Arbiter and sequencer for the SISC core's single unified 4096×32 memory. It shares the one memory port between three requesters:
- instruction fetch (IF);
- load/store execute (LS);
- program loader/debug port (LD).

It issues at most one access per cycle, returns read data with fixed one-cycle latency, and lets the loader lock the memory for exclusive bulk loads. It sits between the core's fetch/execute units and the synchronous SRAM macro.

## Interface
- WIDTH, 32, data word width
- ADDRSIZE, 12, word address width (memory depth 1<<ADDRSIZE)

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- if_req, ls_req, ld_req  in  1 each  access request, held until granted
- if_addr, ls_addr, ld_addr  in  ADDRSIZE each  word address
- ls_we, ld_we  in  1 each  1=write, 0=read (IF is read-only)
- ls_wdata, ld_wdata  in  WIDTH each  write data
- ld_lock  in  1  loader requests exclusive ownership
- if_gnt, ls_gnt, ld_gnt  out  1 each  access issued this cycle
- if_rvalid, ls_rvalid, ld_rvalid  out  1 each  rdata valid for that requester
- rdata  out  WIDTH  read data, shared by all requesters (= mem_rdata)
- locked  out  1  arbiter is in LOCKED state
- mem_en, mem_we  out  1 each  memory strobe / write enable
- mem_addr  out  ADDRSIZE  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid one cycle after a read strobe

## Operation
- FSM has two states, RUN and LOCKED. Reset state is RUN.
- RUN priority:
  - LD has the highest priority.
  - IF and LS are served round-robin. rr_ptr names the favoured one.
  - After IF is granted, rr_ptr moves to LS. After LS is granted, it moves to IF.
  - rr_ptr is unchanged when neither IF nor LS is granted.
- RUN→LOCKED: LD is granted while ld_lock=1.
- In LOCKED:
  - only LD can be granted; IF and LS requests wait, gnt stays 0;
  - rr_ptr is frozen.
- LOCKED→RUN: ld_lock=0 sampled in LOCKED. The cycle that samples ld_lock=0 still uses LOCKED grant rules.
- Grant and memory drive are combinational from the current state, rr_ptr and the requests:
  - exactly one gnt is high when any eligible request exists;
  - mem_en = OR of the gnts;
  - mem_we/mem_addr/mem_wdata are muxed from the granted requester;
  - an IF grant forces mem_we=0.
- Read return: a one-deep tag register records which requester was granted a read (mem_we=0). The next cycle, that requester's rvalid=1. Writes produce no rvalid.
- Requesters must hold addr/we/wdata stable while req=1 and gnt=0. Dropping req before grant is allowed and cancels the request.
- Address arithmetic: none. Addresses pass through unmodified at ADDRSIZE bits, so no wrap is possible.

## Timing
- Reset values (asserted on clk edge with reset=0):
  - state=RUN, rr_ptr=IF, read tag cleared;
  - all rvalid=0, locked=0.
  - gnt and mem_en are 0 whenever reset=0.
- Read latency: gnt in cycle N → rvalid and rdata in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads from the same requester return on consecutive cycles.
- Simultaneous IF+LS requests with no LD request alternate every cycle.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid. LOCKED is abandoned.
- locked is registered and reflects the state.

## Structure
- The shared package sisc_pkg holds:
  - WIDTH and ADDRSIZE constants;
  - the requester index enum (REQ_IF, REQ_LS, REQ_LD);
  - the arbiter state enum (ST_RUN, ST_LOCKED).
- One sub-module, sisc_rr_arb2: a two-way round-robin picker with an inputs/pointer/grant/update interface, used for IF vs LS.

## Test plan
- Reset: hold reset=0 for 2 cycles with all reqs=1 → all gnt=0, rvalid=0, mem_en=0, locked=0.
- Round-robin: if_req=ls_req=1 continuously, addresses 0x010/0x020, LD idle → grants alternate IF, LS, IF, LS starting with IF. Each rvalid follows one cycle later with mem contents.
- Loader priority and lock: all three request, ld_lock=1, ld_addr=0x100 write 0xDEADBEEF:
  - ld_gnt is asserted and locked=1 the next cycle;
  - IF/LS gnt stay 0 across 4 locked LD writes;
  - after ld_lock=0, LOCKED persists for one more cycle, then RUN resumes with the rr_ptr value it had before the lock.
- Write/read: LS writes 0x0000CAFE to 0x3FF, then reads 0x3FF → no rvalid for the write; ls_rvalid=1 with rdata=0x0000CAFE one cycle after the read grant.
- Request withdrawal: ls_req is raised for one cycle while LD holds the port, then dropped → no LS access reaches memory (mem_en is never high with the LS address).
- Reset mid-read: IF read granted in cycle N, reset=0 at the edge ending cycle N → if_rvalid stays 0 in N+1.
